// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, sequencer states, IR field positions and opcode classifiers.
package alu_ctrl_pkg;
  localparam int OPC_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHRA = 5'b01000;
  localparam logic [4:0] OPC_SHL  = 5'b01001;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_NEG  = 5'b01100;
  localparam logic [4:0] OPC_NOT  = 5'b01101;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;
  function automatic logic is_rr_alu(input logic [4:0] opc);
    return opc >= OPC_ADD && opc <= OPC_NOT;
  endfunction
  function automatic logic is_muldiv(input logic [4:0] opc);
    return opc == OPC_MUL || opc == OPC_DIV;
  endfunction
endpackage

// File: rtl/alu_ctrl_mem_wait.sv
// alu_ctrl_mem_wait: counts consecutive memory wait cycles, flags the last allowed one.
module alu_ctrl_mem_wait #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt <= '0;
    else cnt <= (active && !ready) ? cnt + 1'b1 : '0;
  // fires on the TIMEOUT-th wait cycle that still sees no ready
  assign timeout = active && !ready && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: Moore fetch/execute sequencer for three-register ALU instructions.
// Define ALU_SEQ_MULDIV_EN to enable MUL/DIV (T6 with lo_in/hi_in); otherwise they are illegal.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int REG_SEL_W = 4,
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 run,
  input  logic [31:0]          ir_data,
  input  logic                 mem_ready,
  output logic                 pc_out,
  output logic                 mar_in,
  output logic                 inc_pc,
  output logic                 z_in,
  output logic                 zlow_out,
  output logic                 zhigh_out,
  output logic                 pc_in,
  output logic                 read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic                 y_in,
  output logic                 lo_in,
  output logic                 hi_in,
  output logic                 rout,
  output logic                 rin,
  output logic [REG_SEL_W-1:0] rout_sel,
  output logic [REG_SEL_W-1:0] rin_sel,
  output logic [OPC_W-1:0]     alu_op,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 mem_err
);
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif
  state_t state, state_nx;
  logic retire, set_illegal, timeout, rr, md, unused;
  logic [OPC_W-1:0] opc;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  state_t boundary;
  assign opc = ir_data[OPC_LSB +: OPC_W];
  assign ra = ir_data[RA_LSB +: REG_SEL_W];
  assign rb = ir_data[RB_LSB +: REG_SEL_W];
  assign rc = ir_data[RC_LSB +: REG_SEL_W];
  assign unused = ^ir_data[RC_LSB-1:0];
  assign rr = is_rr_alu(opc);
  assign md = MULDIV_EN && is_muldiv(opc);
  assign boundary = run ? S_T0 : S_IDLE;
  alu_ctrl_mem_wait #(.TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk(clk), .clr(clr), .active(state == S_T1W), .ready(mem_ready), .timeout(timeout)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= S_IDLE;
      retired_cnt <= '0;
      illegal_op <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      if (set_illegal) illegal_op <= 1'b1;
      if (timeout) mem_err <= 1'b1;
    end
  always_comb begin
    {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read} = '0;
    {mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in, rout, rin, halted} = '0;
    rout_sel = '0;
    rin_sel = '0;
    alu_op = '0;
    retire = 1'b0;
    set_illegal = 1'b0;
    state_nx = state;
    case (state)
      S_IDLE: state_nx = boundary;
      S_T0: begin
        {pc_out, mar_in, inc_pc, z_in} = '1;
        state_nx = S_T1;
      end
      S_T1: begin
        {zlow_out, pc_in, read, mdr_in} = '1;
        state_nx = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        {read, mdr_in} = '1;
        state_nx = mem_ready ? S_T2 : timeout ? S_HALTED : S_T1W;
      end
      S_T2: begin
        {mdr_out, ir_in} = '1;
        state_nx = S_T3;
      end
      S_T3: begin
        if (rr || md) begin
          {rout, y_in} = '1;
          rout_sel = rb;
          state_nx = S_T4;
        end else if (opc == OPC_NOP) begin
          retire = 1'b1;
          state_nx = boundary;
        end else begin
          set_illegal = opc != OPC_HALT;
          state_nx = S_HALTED;
        end
      end
      S_T4: begin
        {rout, z_in} = '1;
        rout_sel = rc;
        alu_op = opc;
        state_nx = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        lo_in = md;
        rin = !md;
        rin_sel = md ? '0 : ra;
        retire = !md;
        state_nx = md ? S_T6 : boundary;
      end
      S_T6: begin
        {zhigh_out, hi_in} = {2{MULDIV_EN}};
        retire = 1'b1;
        state_nx = boundary;
      end
      S_HALTED: halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb_alu_ctrl_sequencer: directed per-cycle checks of the fetch/execute sequencer.
module tb_alu_ctrl_sequencer;
  localparam logic [15:0] PCO = 16'h8000, MARI = 16'h4000, INCP = 16'h2000, ZIN = 16'h1000;
  localparam logic [15:0] ZLO = 16'h0800, ZHI = 16'h0400, PCI = 16'h0200, RD = 16'h0100;
  localparam logic [15:0] MDRI = 16'h0080, MDRO = 16'h0040, IRI = 16'h0020, YIN = 16'h0010;
  localparam logic [15:0] LOI = 16'h0008, HII = 16'h0004, RO = 16'h0002, RI = 16'h0001;
  localparam logic [31:0] IR_SHRA = 32'h409A8000, IR_NOP = 32'hD0000000;
  localparam logic [31:0] IR_BAD = 32'hF8000000, IR_HALT = 32'hD8000000, IR_MUL = 32'h791A0000;
  logic clk = 1'b0, clr = 1'b1, run = 1'b0, mem_ready = 1'b1;
  logic [31:0] ir_data = '0;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out;
  logic ir_in, y_in, lo_in, hi_in, rout, rin, halted, illegal_op, mem_err;
  logic [3:0] rout_sel, rin_sel;
  logic [4:0] alu_op;
  logic [15:0] retired_cnt, strb;
  logic [28:0] obs;
  int n_cmp = 0, n_bad = 0, exp_ret = 0;
  always #5 clk = ~clk;
  alu_ctrl_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir_data(ir_data), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in), .lo_in(lo_in), .hi_in(hi_in), .rout(rout), .rin(rin),
    .rout_sel(rout_sel), .rin_sel(rin_sel), .alu_op(alu_op), .retired_cnt(retired_cnt),
    .halted(halted), .illegal_op(illegal_op), .mem_err(mem_err)
  );
  assign strb = {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read,
                 mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in, rout, rin};
  assign obs = {strb, rout_sel, rin_sel, alu_op};
  function automatic logic [28:0] ex(input logic [15:0] s, input logic [3:0] ro, input logic [3:0] ri,
                                     input logic [4:0] op);
    return {s, ro, ri, op};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_clr;
    clr = 1'b1;
    run = 1'b0;
    #1;
    clr = 1'b0;
    exp_ret = 0;
  endtask
  task automatic test_reset;
    step;
    step;
    n_cmp++;
    if ({obs, halted, illegal_op, mem_err, retired_cnt} !== 48'd0) begin
      n_bad++;
      $display("FAIL reset_hold got %h want 0", {obs, halted, illegal_op, mem_err, retired_cnt});
    end
    clr = 1'b0;
    step;
    n_cmp++;
    if ({obs, halted} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_idle got %h want 0", {obs, halted});
    end
  endtask
  task automatic test_rr;
    logic [28:0] e [6];
    e = '{ex(PCO|MARI|INCP|ZIN, 0, 0, 0), ex(ZLO|PCI|RD|MDRI, 0, 0, 0), ex(MDRO|IRI, 0, 0, 0),
          ex(RO|YIN, 3, 0, 0), ex(RO|ZIN, 5, 0, 5'b01000), ex(ZLO|RI, 0, 1, 0)};
    ir_data = IR_SHRA;
    run = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL rr_step%0d got %h want %h", i, obs, e[i]);
      end
      if (i == 4) run = 1'b0;
    end
    step;
    exp_ret++;
    n_cmp++;
    if ({obs, retired_cnt} !== {29'd0, 16'(exp_ret)}) begin
      n_bad++;
      $display("FAIL rr_retire got %h/%0d want 0/%0d", obs, retired_cnt, exp_ret);
    end
  endtask
  task automatic test_back_to_back;
    logic [28:0] e [4];
    e = '{ex(PCO|MARI|INCP|ZIN, 0, 0, 0), ex(ZLO|PCI|RD|MDRI, 0, 0, 0), ex(MDRO|IRI, 0, 0, 0), 29'd0};
    ir_data = IR_NOP;
    run = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        step;
        n_cmp++;
        if (obs !== e[i] || (i == 0 && retired_cnt !== 16'(exp_ret))) begin
          n_bad++;
          $display("FAIL b2b_p%0d_s%0d got %h/%0d want %h/%0d", p, i, obs, retired_cnt, e[i], exp_ret);
        end
        if (p == 1 && i == 2) run = 1'b0;
      end
      exp_ret++;
    end
    step;
    n_cmp++;
    if ({obs, retired_cnt} !== {29'd0, 16'(exp_ret)}) begin
      n_bad++;
      $display("FAIL b2b_end got %h/%0d want 0/%0d", obs, retired_cnt, exp_ret);
    end
  endtask
  task automatic test_mem_wait;
    logic [28:0] e [6];
    e = '{ex(PCO|MARI|INCP|ZIN, 0, 0, 0), ex(ZLO|PCI|RD|MDRI, 0, 0, 0), ex(RD|MDRI, 0, 0, 0),
          ex(RD|MDRI, 0, 0, 0), ex(RD|MDRI, 0, 0, 0), ex(MDRO|IRI, 0, 0, 0)};
    ir_data = IR_SHRA;
    run = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      n_cmp++;
      if (obs !== e[i] || mem_err !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_step%0d got %h err=%b want %h err=0", i, obs, mem_err, e[i]);
      end
      if (i == 0) mem_ready = 1'b0;
      if (i == 4) mem_ready = 1'b1;
    end
    run = 1'b0;
    repeat (4) step;
    exp_ret++;
    n_cmp++;
    if ({obs, mem_err, halted, retired_cnt} !== {31'd0, 16'(exp_ret)}) begin
      n_bad++;
      $display("FAIL wait_end got %h err=%b halt=%b ret=%0d want ret=%0d", obs, mem_err, halted,
               retired_cnt, exp_ret);
    end
  endtask
  task automatic test_timeout;
    ir_data = IR_SHRA;
    run = 1'b1;
    mem_ready = 1'b0;
    step;
    step;
    for (int w = 0; w < 15; w++) begin
      step;
      n_cmp++;
      if (obs !== ex(RD|MDRI, 0, 0, 0) || {halted, mem_err} !== 2'b00) begin
        n_bad++;
        $display("FAIL timeout_wait%0d got %h halt/err=%b%b", w, obs, halted, mem_err);
      end
    end
    step;
    n_cmp++;
    if ({obs, halted, mem_err} !== {29'd0, 2'b11}) begin
      n_bad++;
      $display("FAIL timeout_halt got %h halt/err=%b%b want 0 11", obs, halted, mem_err);
    end
    mem_ready = 1'b1;
    repeat (3) step;
    n_cmp++;
    if ({obs, halted, mem_err} !== {29'd0, 2'b11}) begin
      n_bad++;
      $display("FAIL timeout_stuck got %h halt/err=%b%b want 0 11", obs, halted, mem_err);
    end
    pulse_clr;
    n_cmp++;
    if ({halted, mem_err, retired_cnt} !== 18'd0) begin
      n_bad++;
      $display("FAIL timeout_clr halt/err=%b%b ret=%0d want 0", halted, mem_err, retired_cnt);
    end
  endtask
  task automatic test_illegal;
    ir_data = IR_BAD;
    run = 1'b1;
    repeat (4) step;
    n_cmp++;
    if ({obs, illegal_op, halted} !== 31'd0) begin
      n_bad++;
      $display("FAIL illegal_t3 got %h ill/halt=%b%b want 0", obs, illegal_op, halted);
    end
    for (int i = 0; i < 5; i++) begin
      step;
      n_cmp++;
      if ({rin, obs, illegal_op, halted} !== {1'b0, 29'd0, 2'b11}) begin
        n_bad++;
        $display("FAIL illegal_after%0d got rin=%b %h ill/halt=%b%b", i, rin, obs, illegal_op, halted);
      end
    end
    pulse_clr;
    n_cmp++;
    if ({illegal_op, halted} !== 2'b00) begin
      n_bad++;
      $display("FAIL illegal_clr ill/halt=%b%b want 00", illegal_op, halted);
    end
    ir_data = IR_HALT;
    run = 1'b1;
    repeat (5) step;
    n_cmp++;
    if ({obs, illegal_op, halted} !== {29'd0, 2'b01}) begin
      n_bad++;
      $display("FAIL halt_op got %h ill/halt=%b%b want 0 01", obs, illegal_op, halted);
    end
    pulse_clr;
  endtask
  task automatic test_clr_t4;
    ir_data = IR_SHRA;
    run = 1'b1;
    mem_ready = 1'b1;
    repeat (5) step;
    n_cmp++;
    if (obs !== ex(RO|ZIN, 5, 0, 5'b01000)) begin
      n_bad++;
      $display("FAIL clr_t4_pre got %h", obs);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if ({obs, halted, retired_cnt} !== 46'd0) begin
      n_bad++;
      $display("FAIL clr_t4_async got %h halt=%b ret=%0d want 0", obs, halted, retired_cnt);
    end
    clr = 1'b0;
    run = 1'b0;
    step;
    n_cmp++;
    if (obs !== 29'd0) begin
      n_bad++;
      $display("FAIL clr_t4_idle got %h want 0", obs);
    end
  endtask
  task automatic test_muldiv;
    ir_data = IR_MUL;
    run = 1'b1;
    mem_ready = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
    begin
      logic [28:0] e [7];
      e = '{ex(PCO|MARI|INCP|ZIN, 0, 0, 0), ex(ZLO|PCI|RD|MDRI, 0, 0, 0), ex(MDRO|IRI, 0, 0, 0),
            ex(RO|YIN, 3, 0, 0), ex(RO|ZIN, 4, 0, 5'b01111), ex(ZLO|LOI, 0, 0, 0), ex(ZHI|HII, 0, 0, 0)};
      for (int i = 0; i < 7; i++) begin
        step;
        n_cmp++;
        if (obs !== e[i]) begin
          n_bad++;
          $display("FAIL mul_step%0d got %h want %h", i, obs, e[i]);
        end
        if (i == 5) run = 1'b0;
      end
      step;
      n_cmp++;
      if ({obs, illegal_op, retired_cnt} !== {30'd0, 16'd1}) begin
        n_bad++;
        $display("FAIL mul_retire got %h ill=%b ret=%0d want 0 0 1", obs, illegal_op, retired_cnt);
      end
    end
`else
    repeat (4) step;
    n_cmp++;
    if (obs !== 29'd0) begin
      n_bad++;
      $display("FAIL mul_t3 got %h want 0", obs);
    end
    step;
    n_cmp++;
    if ({obs, illegal_op, halted} !== {29'd0, 2'b11}) begin
      n_bad++;
      $display("FAIL mul_illegal got %h ill/halt=%b%b want 0 11", obs, illegal_op, halted);
    end
`endif
    pulse_clr;
  endtask
  initial begin
    test_reset;
    test_rr;
    test_back_to_back;
    test_mem_wait;
    test_timeout;
    test_illegal;
    test_clr_t4;
    test_muldiv;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
